hazard_ctrl_mc: RTL and testbench

Hazard control for the 5-stage RV32 pipeline (F/D/E/M/W), replacing the purely combinational hazard unit.
- Existing duties: forwarding select, load-use stall, branch flush.
- New: parametrised register-index width.
- New: a counter-driven stall for multi-cycle E-stage ops (mul/div).
- New: a data-memory wait handshake that freezes F–M.
- New: saturating stall/flush performance counters.

The block sits beside the pipeline registers and drives their stall/flush enables and the E-stage operand muxes.

---
 rtl/hazard_ctrl_mc_pkg.sv | 17 +
 rtl/hazard_ctrl_mc_if.sv | 39 +++
 rtl/hazard_ctrl_mc_sat_counter.sv | 19 +
 rtl/hazard_ctrl_mc.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_pkg;

  // E-stage operand source select
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_M  = 2'b01,
    FWD_W  = 2'b10
  } fwd_sel_t;

  // Multi-cycle sequencer state
  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Pipeline <-> hazard controller signal bundle.
// slave: the hazard controller; master: the pipeline side.
interface hazard_ctrl_mc_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  // register indices
  logic [ADDR_W-1:0] rs1_d, rs2_d, rs1_e, rs2_e;
  logic [ADDR_W-1:0] rd_e, rd_m, rd_w;
  // stage status
  logic reg_write_e, reg_write_m, reg_write_w;
  logic mem_to_reg_e, mc_op_e, pc_src_e;
  logic dmem_req_m, dmem_ready_m;
  // pipeline register controls
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic mc_busy;
  // performance counters
  logic [CNT_W-1:0] stall_cycles, flush_count;

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  reg_write_e, reg_write_m, reg_write_w,
    input  mem_to_reg_e, mc_op_e, pc_src_e, dmem_req_m, dmem_ready_m,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_m, flush_w,
    output fwd_a_e, fwd_b_e, mc_busy, stall_cycles, flush_count
  );

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output reg_write_e, reg_write_m, reg_write_w,
    output mem_to_reg_e, mc_op_e, pc_src_e, dmem_req_m, dmem_ready_m,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_m, flush_w,
    input  fwd_a_e, fwd_b_e, mc_busy, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_mc_sat_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count up until the top value, then hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage pipeline: operand forwarding,
// load-use stall, branch flush, multi-cycle E-stage ops, data-memory
// wait freeze, and saturating stall/flush counters.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst_n,
  hazard_ctrl_mc_if.slave hz
);

  // cnt counts the remaining stall cycles after the first one
  localparam int              CW       = $clog2(MC_LAT) + 1;
  localparam bit              MC_EN    = (MC_LAT >= 2);
  localparam logic [CW-1:0]   CNT_INIT = MC_EN ? CW'(MC_LAT - 2) : '0;

  hz_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic mem_wait, mc_start, mc_stall, load_use, stall_e_int;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;

  // newest producer wins: M over W; x0 never forwards
  function automatic fwd_sel_t fwd_pick(input logic [ADDR_W-1:0] rs);
    if (hz.reg_write_m && (hz.rd_m != '0) && (hz.rd_m == rs))
      return FWD_M;
    else if (hz.reg_write_w && (hz.rd_w != '0) && (hz.rd_w == rs))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

  assign hz.fwd_a_e = fwd_pick(hz.rs1_e);
  assign hz.fwd_b_e = fwd_pick(hz.rs2_e);

  assign mem_wait = hz.dmem_req_m & ~hz.dmem_ready_m;
  assign mc_start = MC_EN && (state == RUN) && hz.mc_op_e;
  assign load_use = hz.mem_to_reg_e & hz.reg_write_e & (hz.rd_e != '0) &
                    ((hz.rd_e == hz.rs1_d) | (hz.rd_e == hz.rs2_d));

  // multi-cycle sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // sequencer next state; a memory wait freezes the whole sequencer
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mc_stall  = 1'b0;
    case (state)
      RUN: begin
        if (mc_start) begin
          mc_stall  = 1'b1;
          state_nxt = MC_BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      MC_BUSY: begin
        if (cnt != '0) begin
          mc_stall = 1'b1;
          cnt_nxt  = cnt - CW'(1);
        end else begin
          // final occupancy cycle: E advances
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (mem_wait) begin
      state_nxt = state;
      cnt_nxt   = cnt;
    end
  end

  assign stall_e_int = mem_wait | mc_stall;

  // stall/flush priority: memory wait, then multi-cycle, then branch, then load-use
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      if (mc_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end
      // a branch held behind a stall resolves when E finally advances
      if (hz.pc_src_e && !stall_e_int) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      // the dependent instruction is squashed anyway if the branch is taken
      if (load_use && !stall_e_int && !hz.pc_src_e) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
    if (!rst_n) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      flush_w = 1'b0;
    end
  end

  assign hz.stall_f = stall_f;
  assign hz.stall_d = stall_d;
  assign hz.stall_e = stall_e;
  assign hz.stall_m = stall_m;
  assign hz.flush_d = flush_d;
  assign hz.flush_e = flush_e;
  assign hz.flush_m = flush_m;
  assign hz.flush_w = flush_w;
  assign hz.mc_busy = rst_n & ((state == MC_BUSY) | mc_start);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_f),
    .count (hz.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_d),
    .count (hz.flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: directed scenarios with literal expectations,
// then random traffic against a behavioural occupancy model. A second
// instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_hazard_ctrl_mc;
  localparam int MC_LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc_if #(.ADDR_W(5), .CNT_W(16)) hif ();
  hazard_ctrl_mc_if #(.ADDR_W(5), .CNT_W(2))  hif2 ();

  hazard_ctrl_mc #(.ADDR_W(5), .MC_LAT(MC_LAT), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .hz(hif.slave));
  hazard_ctrl_mc #(.ADDR_W(5), .MC_LAT(MC_LAT), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .hz(hif2.slave));

  assign hif2.rs1_d        = hif.rs1_d;
  assign hif2.rs2_d        = hif.rs2_d;
  assign hif2.rs1_e        = hif.rs1_e;
  assign hif2.rs2_e        = hif.rs2_e;
  assign hif2.rd_e         = hif.rd_e;
  assign hif2.rd_m         = hif.rd_m;
  assign hif2.rd_w         = hif.rd_w;
  assign hif2.reg_write_e  = hif.reg_write_e;
  assign hif2.reg_write_m  = hif.reg_write_m;
  assign hif2.reg_write_w  = hif.reg_write_w;
  assign hif2.mem_to_reg_e = hif.mem_to_reg_e;
  assign hif2.mc_op_e      = hif.mc_op_e;
  assign hif2.pc_src_e     = hif.pc_src_e;
  assign hif2.dmem_req_m   = hif.dmem_req_m;
  assign hif2.dmem_ready_m = hif.dmem_ready_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    hif.rs1_d = '0; hif.rs2_d = '0; hif.rs1_e = '0; hif.rs2_e = '0;
    hif.rd_e = '0; hif.rd_m = '0; hif.rd_w = '0;
    hif.reg_write_e = 1'b0; hif.reg_write_m = 1'b0; hif.reg_write_w = 1'b0;
    hif.mem_to_reg_e = 1'b0; hif.mc_op_e = 1'b0; hif.pc_src_e = 1'b0;
    hif.dmem_req_m = 1'b0; hif.dmem_ready_m = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    hif.rs1_d = 5'($urandom_range(0, 3));
    hif.rs2_d = 5'($urandom_range(0, 3));
    hif.rs1_e = 5'($urandom_range(0, 3));
    hif.rs2_e = 5'($urandom_range(0, 3));
    hif.rd_e  = 5'($urandom_range(0, 3));
    hif.rd_m  = 5'($urandom_range(0, 3));
    hif.rd_w  = 5'($urandom_range(0, 3));
    hif.reg_write_e  = 1'($urandom_range(0, 1));
    hif.reg_write_m  = 1'($urandom_range(0, 1));
    hif.reg_write_w  = 1'($urandom_range(0, 1));
    hif.mem_to_reg_e = ($urandom_range(0, 2) == 0);
    hif.mc_op_e      = ($urandom_range(0, 4) == 0);
    hif.pc_src_e     = ($urandom_range(0, 6) == 0);
    hif.dmem_req_m   = 1'($urandom_range(0, 1));
    hif.dmem_ready_m = ($urandom_range(0, 2) != 0);
  endtask

  // ---------------- behavioural model ----------------
  // age: stalled cycles the current multi-cycle op has spent in E so far.
  int age = 0;
  int ms  = 0;  // cycles with stall_f
  int mf  = 0;  // cycles with flush_d

  function automatic logic [1:0] mfwd(input logic [4:0] rs);
    if (rs != 0 && hif.reg_write_m && hif.rd_m == rs) return 2'b01;
    if (rs != 0 && hif.reg_write_w && hif.rd_w == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  // every cycle: derive the required outputs and compare both instances
  always @(negedge clk) begin : scoreboard
    logic mw, occ, mcs, sei, lu, luq, br;
    logic sf, sd, se, sm, fd, fe, fm, fw, busy;
    logic [12:0] e, a0, a1;
    mw   = hif.dmem_req_m && !hif.dmem_ready_m;
    occ  = (age > 0) || hif.mc_op_e;
    mcs  = !mw && occ && (age < MC_LAT - 1);
    sei  = mw || mcs;
    lu   = hif.mem_to_reg_e && hif.reg_write_e && hif.rd_e != 0 &&
           (hif.rd_e == hif.rs1_d || hif.rd_e == hif.rs2_d);
    br   = hif.pc_src_e && !sei;
    luq  = lu && !sei && !hif.pc_src_e;
    sf   = sei || luq;
    sd   = sei || luq;
    se   = sei;
    sm   = mw;
    fd   = br;
    fe   = br || luq;
    fm   = mcs;
    fw   = mw;
    busy = (age > 0) || (hif.mc_op_e && MC_LAT >= 2);
    if (!rst_n) begin
      {sf, sd, se, sm, fd, fe, fm, fw, busy} = '0;
      age = 0; ms = 0; mf = 0;
    end
    e  = {sf, sd, se, sm, fd, fe, fm, fw, busy, mfwd(hif.rs1_e), mfwd(hif.rs2_e)};
    a0 = {hif.stall_f, hif.stall_d, hif.stall_e, hif.stall_m, hif.flush_d, hif.flush_e,
          hif.flush_m, hif.flush_w, hif.mc_busy, hif.fwd_a_e, hif.fwd_b_e};
    a1 = {hif2.stall_f, hif2.stall_d, hif2.stall_e, hif2.stall_m, hif2.flush_d, hif2.flush_e,
          hif2.flush_m, hif2.flush_w, hif2.mc_busy, hif2.fwd_a_e, hif2.fwd_b_e};
    chk("ctl_u0", 32'(a0), 32'(e));
    chk("ctl_u1", 32'(a1), 32'(e));
    chk("stall_cycles_u0", 32'(hif.stall_cycles), 32'(sat(ms, 16)));
    chk("flush_count_u0", 32'(hif.flush_count), 32'(sat(mf, 16)));
    chk("stall_cycles_u1", 32'(hif2.stall_cycles), 32'(sat(ms, 2)));
    chk("flush_count_u1", 32'(hif2.flush_count), 32'(sat(mf, 2)));
    if (rst_n) begin
      if (sf) ms++;
      if (fd) mf++;
      if (!mw && occ) age = (age < MC_LAT - 1) ? age + 1 : 0;
    end
  end

  // ---------------- directed then random ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_ctl", 32'({hif.stall_f, hif.stall_e, hif.flush_d, hif.flush_w, hif.mc_busy}), 32'd0);
    chk("rst_cnt", 32'(hif.stall_cycles), 32'd0);
    step(); rst_n = 1'b1;

    // forwarding priority
    hif.rd_m = 5; hif.rd_w = 5; hif.rs1_e = 5; hif.reg_write_m = 1; hif.reg_write_w = 1;
    @(negedge clk); chk("fwd_m", 32'(hif.fwd_a_e), 32'd1);
    step(); hif.rd_m = 0;
    @(negedge clk); chk("fwd_w", 32'(hif.fwd_a_e), 32'd2);
    step(); hif.rs1_e = 0;
    @(negedge clk); chk("fwd_rf", 32'(hif.fwd_a_e), 32'd0);

    // load-use, then load-use under a taken branch
    step(); idle(); hif.mem_to_reg_e = 1; hif.reg_write_e = 1; hif.rd_e = 7; hif.rs2_d = 7;
    @(negedge clk); chk("lu_stall", 32'({hif.stall_f, hif.stall_d, hif.flush_e, hif.flush_d}), 32'b1110);
    step(); idle();
    @(negedge clk); chk("lu_cnt", 32'(hif.stall_cycles), 32'd1);
    step(); hif.mem_to_reg_e = 1; hif.reg_write_e = 1; hif.rd_e = 7; hif.rs2_d = 7; hif.pc_src_e = 1;
    @(negedge clk); chk("lu_br", 32'({hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e}), 32'b0011);
    step(); idle();
    @(negedge clk); chk("br_cnt", 32'(hif.flush_count), 32'd1);

    // multi-cycle op occupying E for MC_LAT cycles
    for (int i = 0; i < 4; i++) begin
      step(); idle(); hif.mc_op_e = 1;
      @(negedge clk);
      chk("mc_stall", 32'({hif.stall_e, hif.flush_m}), (i < 3) ? 32'b11 : 32'b00);
      if (i < 3) chk("mc_busy", 32'(hif.mc_busy), 32'd1);
    end
    step(); idle();
    @(negedge clk); chk("mc_idle", 32'(hif.mc_busy), 32'd0);
    chk("mc_cnt", 32'(hif.stall_cycles), 32'd4);

    // memory wait arriving while cnt=1
    for (int i = 0; i < 7; i++) begin
      step(); idle(); hif.mc_op_e = 1;
      if (i >= 2 && i <= 4) begin hif.dmem_req_m = 1; hif.dmem_ready_m = 0; end
      @(negedge clk);
      chk("mw_mc", 32'({hif.stall_e, hif.stall_m, hif.flush_m, hif.flush_w}),
          (i >= 2 && i <= 4) ? 32'b1101 : (i == 6) ? 32'b0000 : 32'b1010);
    end
    step(); idle();
    @(negedge clk); chk("mw_cnt", 32'(hif.stall_cycles), 32'd10);

    // taken branch held behind a memory wait
    step(); idle(); hif.pc_src_e = 1; hif.dmem_req_m = 1; hif.dmem_ready_m = 0;
    @(negedge clk); chk("br_wait", 32'({hif.flush_d, hif.flush_e, hif.flush_w}), 32'b001);
    step(); hif.dmem_ready_m = 1;
    @(negedge clk); chk("br_go", 32'({hif.flush_d, hif.flush_e}), 32'b11);
    step(); idle();
    @(negedge clk);
    chk("br_fcnt", 32'(hif.flush_count), 32'd2);
    chk("br_scnt", 32'(hif.stall_cycles), 32'd11);
    chk("sat_early", 32'(hif2.stall_cycles), 32'd3);

    // asynchronous reset in the middle of MC_BUSY
    step(); hif.mc_op_e = 1;
    step();
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mc_ctl", 32'({hif.stall_f, hif.stall_e, hif.flush_m, hif.mc_busy}), 32'd0);
    chk("rst_mc_cnt", 32'({hif.stall_cycles, hif.flush_count}), 32'd0);
    step(); rst_n = 1'b1; idle();
    @(negedge clk); chk("rst_run", 32'({hif.mc_busy, hif.stall_e}), 32'd0);

    // five stall cycles: 2-bit counter pins at 3
    for (int i = 0; i < 5; i++) begin
      step(); idle(); hif.dmem_req_m = 1;
    end
    step(); idle();
    @(negedge clk);
    chk("sat_u1", 32'(hif2.stall_cycles), 32'd3);
    chk("sat_u0", 32'(hif.stall_cycles), 32'd5);

    // random traffic with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      step();
      rand_inputs();
      rst_n = ($urandom_range(0, 399) != 0);
    end
    step(); idle(); rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
